seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller. It is the successor to the fixed 8-digit anode-walk/segment-shift demo. Hex data is captured into a pending buffer and committed tear-free at frame boundaries, then decoded per digit. The block adds per-digit blanking, decimal points, an inter-digit ghosting guard and PWM brightness. It sits between user logic and the board's active-low anode/cathode pins.

Parameters:
N_DIGITS, 8, number of digits scanned (1..16)
TICK_DIV, 100000, clocks per digit slot (1 ms at 100 MHz); must be >= GUARD+2
GUARD, 4, clocks at the start of each slot during which all anodes are off
BRIGHT_W, 4, brightness input width

Ports:
clk100mhz  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
data_in  in  4*N_DIGITS  hex nibble per digit; digit k = data_in[4k+3:4k]
dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
blank_in  in  N_DIGITS  1 = digit forced dark
load  in  1  1-cycle strobe; captures data_in/dp_in/blank_in into pending
bright  in  BRIGHT_W  brightness level; all-ones = full on, 0 = dark
an  out  N_DIGITS  anodes, active-low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal-point cathode, active-low
digit_idx  out  max(1,clog2(N_DIGITS))  digit currently in its slot
frame_tick  out  1  1-cycle pulse when digit_idx wraps to 0

Behaviour:
- Reset (rst=0, async): an all 1; seg 7'h7F; dp 1; frame_tick 0; digit_idx 0. Tick counter, PWM counter, display regs, pending regs and pend_valid are all 0.
- Tick counter runs 0..TICK_DIV-1. On TICK_DIV-1 it returns to 0 and digit_idx advances; N_DIGITS-1 wraps to 0.
- Wrap cycle:
  - frame_tick=1 for exactly that cycle.
  - If pend_valid=1, display regs <= pending and pend_valid <= 0.
- load=1 at any cycle: pending <= inputs; pend_valid <= 1.
- load in the same cycle as a wrap: the new load data is committed directly to the display regs; pend_valid <= 0.
- A second load before the next wrap overwrites pending; last load wins.
- Decode table, hex to seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- PWM counter (BRIGHT_W bits) free-runs every clock.
  - lit = (bright == all-ones) or (pwm_cnt < bright).
- Digit i drives its anode low only when all of the following hold:
  - digit_idx == i
  - tick counter >= GUARD
  - lit = 1
  - the digit is not blanked
- When no anode is active, seg = 7'h7F and dp = 1.
- Otherwise seg = decode(display nibble) and dp = ~display_dp.
- All outputs are registered: an/seg/dp reflect the internal state of the previous cycle (1-cycle latency). digit_idx and frame_tick are registered alongside and aligned with the state change.
- Reset mid-frame: immediate return to reset values. The scan restarts at digit 0 with tick 0, and pending data is discarded.

Optional Feature:
LZ_BLANK_EN:
- Defined: leading-zero suppression. Every digit above the most significant nonzero display nibble is blanked, in addition to blank_in. Digit 0 is never suppressed, so all zeros shows a single "0". A set display dp on a digit prevents its suppression.
- Undefined: only blank_in blanks digits.

Test Plan:
1. Params N_DIGITS=4, TICK_DIV=8, GUARD=2, bright all-ones. Release reset, load data_in=16'h1234 -> after the first wrap, an cycles 1110, 1101, 1011, 0111. Digit 0 shows seg=0011001 ('4'), digit 3 shows seg=1111001 ('1'). Anodes stay 1111 for the 2 guard clocks of each slot; frame_tick pulses every 32 clocks.
2. Load 16'hABCD mid-frame, then 16'h5678 before the wrap -> display still shows the old value until the wrap. Afterwards it shows 5678; ABCD never appears.
3. load coincident with the wrap cycle, data 16'h00F0 -> committed that wrap; the digit 1 slot shows seg=0001110 ('F'); pend_valid is 0 afterwards.
4. blank_in=4'b0100, dp_in=4'b0001 -> digit 2 anode never goes low; digit 0 has dp=0, all other digits dp=1. With LZ_BLANK_EN and data 16'h0070, digits 3 and 2 stay dark and digits 1 and 0 show '7' and '0'.
5. BRIGHT_W=2, bright=2'b01 -> in each slot outside guard, the active anode is low only when pwm_cnt=0 (1 of 4 clocks). bright=0 -> an stays all 1.
6. Assert rst=0 asynchronously mid-slot -> an=1111, seg=7F, dp=1 with no clock edge. After release, digit_idx=0 and the display shows 0000 (blanked to a single "0" with LZ_BLANK_EN).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: tear-free frame commit, PWM dimming, per-slot ghosting guard.
// Latency: an/seg/dp are registered one cycle behind the scan state; digit_idx/frame_tick move with that state.
// Backpressure: none, load is accepted every cycle (last load before a wrap wins). LZ_BLANK_EN adds leading-zero suppression.
module seg7_scan_ctrl #(
    parameter  int N_DIGITS = 8,
    parameter  int TICK_DIV = 100000,
    parameter  int GUARD    = 4,
    parameter  int BRIGHT_W = 4,
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk100mhz,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  load,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0]     tick_cnt;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic [4*N_DIGITS-1:0] pend_data, disp_data;
    logic [N_DIGITS-1:0]   pend_dp, pend_blank, disp_dp, disp_blank;
    logic                  pend_valid;

    logic                  wrap_slot, wrap_frame;
    logic [N_DIGITS-1:0]   blank_eff;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, lit, on;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b1000000;
            4'h1: hex2seg = 7'b1111001;
            4'h2: hex2seg = 7'b0100100;
            4'h3: hex2seg = 7'b0110000;
            4'h4: hex2seg = 7'b0011001;
            4'h5: hex2seg = 7'b0010010;
            4'h6: hex2seg = 7'b0000010;
            4'h7: hex2seg = 7'b1111000;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0010000;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b0000011;
            4'hC: hex2seg = 7'b1000110;
            4'hD: hex2seg = 7'b0100001;
            4'hE: hex2seg = 7'b0000110;
            default: hex2seg = 7'b0001110;
        endcase
    endfunction

    assign wrap_slot  = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign wrap_frame = wrap_slot && (digit_idx == IDX_W'(N_DIGITS - 1));

    always_comb begin
        blank_eff = disp_blank;
`ifdef LZ_BLANK_EN
        // Walk down from the top digit; digit 0 is never part of the zero run.
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
                if (zero_run && !disp_dp[i])
                    blank_eff[i] = 1'b1;
            end
        end
`endif
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = disp_data[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank_eff[i];
            end
        end
        lit = (&bright) || (pwm_cnt < bright);
        on  = (tick_cnt >= TICK_W'(GUARD)) && lit && !cur_blank;

        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++)
            an_nxt[i] = !(on && (digit_idx == IDX_W'(i)));
        if (on) begin
            seg_nxt = hex2seg(cur_nib);
            dp_nxt  = !cur_dp;
        end
    end

    always_ff @(posedge clk100mhz or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            pwm_cnt    <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_tick <= wrap_frame;
            if (wrap_slot) begin
                tick_cnt  <= '0;
                digit_idx <= wrap_frame ? '0 : digit_idx + 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + 1'b1;
            end

            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            // A load landing on the wrap bypasses pending so it is not delayed a whole frame.
            if (wrap_frame && load) begin
                disp_data  <= data_in;
                disp_dp    <= dp_in;
                disp_blank <= blank_in;
                pend_valid <= 1'b0;
            end else if (wrap_frame && pend_valid) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end

            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 8-clock slots, 2-clock guard, 2-bit brightness.
// Expectations switch on LZ_BLANK_EN where leading-zero suppression changes which digits stay dark.
module tb_seg7_scan_ctrl;
    localparam int N  = 4;
    localparam int TD = 8;
    localparam int GD = 2;
    localparam int BW = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, SF = 7'b0001110;

    logic          clk100mhz;
    logic          rst;
    logic [4*N-1:0] data_in;
    logic [N-1:0]  dp_in, blank_in;
    logic          load;
    logic [BW-1:0] bright;
    logic [N-1:0]  an;
    logic [6:0]    seg;
    logic          dp;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int nvec;
    int nerr;

    seg7_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TD), .GUARD(GD), .BRIGHT_W(BW)) dut (
        .clk100mhz (clk100mhz),
        .rst       (rst),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .bright    (bright),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    initial clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk100mhz);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk100mhz);
            n++;
        end while (frame_tick !== 1'b1 && n < 80);
        if (frame_tick !== 1'b1) begin
            nvec++;
            nerr++;
            $error("FAIL %s_timeout: frame_tick observed %b expected 1 within 80 clocks", tag, frame_tick);
        end
    endtask

    // Offset o counts negedges after a frame_tick sample; the outputs there show scan slot (o-1).
    // mode 0 = full brightness, 1 = bright 2'b01 (lit only at tick 4), 2 = dark.
    task automatic check_span(input string tag, input int o_from, input int o_to,
                              input logic [27:0] eseg, input logic [3:0] edp,
                              input logic [3:0] dark, input int mode);
        for (int o = o_from; o <= o_to; o++) begin
            int s, d, k;
            logic on;
            logic [3:0] ean;
            logic [6:0] esg;
            logic edpo;
            @(negedge clk100mhz);
            s = o - 1;
            d = s / 8;
            k = s % 8;
            on = !dark[d] && ((mode == 0 && k >= 2) || (mode == 1 && k == 4));
            ean = 4'hF;
            esg = 7'h7F;
            edpo = 1'b1;
            if (on) begin
                ean[d] = 1'b0;
                esg = eseg[d*7 +: 7];
                edpo = edp[d];
            end
            chk({tag, "_an"}, 32'(an), 32'(ean));
            chk({tag, "_seg"}, 32'(seg), 32'(esg));
            chk({tag, "_dp"}, 32'(dp), 32'(edpo));
            chk({tag, "_idx"}, 32'(digit_idx), 32'((o % 32) / 8));
            chk({tag, "_ftick"}, 32'(frame_tick), 32'(o == 32));
        end
    endtask

    task automatic check_frame(input string tag, input logic [27:0] eseg, input logic [3:0] edp,
                               input logic [3:0] dark, input int mode);
        wait_frame(tag);
        check_span(tag, 1, 32, eseg, edp, dark, mode);
    endtask

    initial begin
        logic [3:0] dark3, dark4, dark6;
`ifdef LZ_BLANK_EN
        dark3 = 4'b1100;
        dark4 = 4'b1100;
        dark6 = 4'b1110;
`else
        dark3 = 4'b0000;
        dark4 = 4'b0100;
        dark6 = 4'b0000;
`endif
        nvec = 0;
        nerr = 0;
        rst = 1'b0;
        load = 1'b0;
        data_in = '0;
        dp_in = '0;
        blank_in = '0;
        bright = 2'b11;

        step(3);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ftick", 32'(frame_tick), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h0);

        // 1: basic scan of 1234
        rst = 1'b1;
        step(1);
        data_in = 16'h1234;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check_frame("t1", {S1, S2, S3, S4}, 4'hF, 4'h0, 0);

        // 2: two loads mid-frame, last wins, nothing shows before the wrap
        step(2);
        data_in = 16'hABCD;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        data_in = 16'h5678;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check_span("t2old", 7, 32, {S1, S2, S3, S4}, 4'hF, 4'h0, 0);
        check_span("t2new", 1, 32, {S5, S6, S7, S8}, 4'hF, 4'h0, 0);

        // 3: load on the wrap cycle commits immediately
        step(31);
        data_in = 16'h00F0;
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t3_wrap_ftick", 32'(frame_tick), 32'h1);
        chk("t3_pend_valid", 32'(dut.pend_valid), 32'h0);
        check_span("t3", 1, 32, {S0, S0, SF, S0}, 4'hF, dark3, 0);
        chk("t3_pend_valid_after", 32'(dut.pend_valid), 32'h0);

        // 4: blanking and decimal point
        data_in = 16'h0070;
        blank_in = 4'b0100;
        dp_in = 4'b0001;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check_frame("t4", {S0, S0, S7, S0}, 4'b1110, dark4, 0);

        // 5: PWM brightness
        bright = 2'b01;
        check_frame("t5q", {S0, S0, S7, S0}, 4'b1110, dark4, 1);
        bright = 2'b00;
        check_frame("t5off", {S0, S0, S7, S0}, 4'b1110, dark4, 2);

        // 6: async reset mid-slot discards pending data
        bright = 2'b11;
        wait_frame("t6pre");
        step(3);
        data_in = 16'h9999;
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t6_active_an", 32'(an), 32'hE);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_an", 32'(an), 32'hF);
        chk("t6_seg", 32'(seg), 32'h7F);
        chk("t6_dp", 32'(dp), 32'h1);
        chk("t6_idx", 32'(digit_idx), 32'h0);
        chk("t6_ftick", 32'(frame_tick), 32'h0);
        chk("t6_pend_valid", 32'(dut.pend_valid), 32'h0);
        step(2);
        rst = 1'b1;
        check_frame("t6", {S0, S0, S0, S0}, 4'hF, dark6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
